// File: rtl/decoder_scan_pkg.sv
// Shared types and sizes for the decoder scan sequencer.
// Slot count and index width match the 4-to-16 decoder it drives.
package decoder_scan_pkg;

   localparam int NUM_SLOTS = 16;
   localparam int SLOT_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      BLANK
   } scan_state_t;

endpackage

// File: rtl/decoder_scan_sequencer_next_slot_finder.sv
// Circular priority search for the next set mask bit after cur_idx.
// A lone set bit at cur_idx is found on the final step (full lap).
module next_slot_finder
   import decoder_scan_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] mask,
   input  logic [SLOT_W-1:0]    cur_idx,
   output logic [SLOT_W-1:0]    next_idx,
   output logic                 wrapped,
   output logic                 none
);

   logic [SLOT_W-1:0] idx;

   always_comb begin
      next_idx = '0;
      none     = 1'b1;
      idx      = '0;
      for (int k = 1; k <= NUM_SLOTS; k++) begin
         idx = cur_idx + SLOT_W'(k);
         if (none && mask[idx]) begin
            next_idx = idx;
            none     = 1'b0;
         end
      end
      wrapped = !none && (next_idx <= cur_idx);
   end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a decoder slot index through a visit mask with a dwell per slot
// and an enable-low blanking gap between slots.
module decoder_scan_sequencer
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = 2
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic [DWELL_W-1:0]   dwell,
   input  logic [NUM_SLOTS-1:0] slot_mask,
   output logic [SLOT_W-1:0]    binary_out,
   output logic                 dec_enable,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [BLANK_W-1:0] BLANK_LOAD =
      BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   scan_state_t       state;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_load;
   logic [BLANK_W-1:0] blank_cnt;
   logic [SLOT_W-1:0]  search_from;
   logic [SLOT_W-1:0]  next_idx;
   logic               wrapped;
   logic               none;
   logic               last_dwell;
   logic               advance;

   // Searching from the top slot in IDLE yields the lowest set bit.
   assign search_from = (state == IDLE) ? SLOT_W'(NUM_SLOTS - 1) : binary_out;
   assign dwell_load  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign last_dwell  = (state == ACTIVE) && (dwell_cnt == '0);
   assign advance     = ((state == BLANK) && (blank_cnt == '0)) ||
                        ((BLANK_CYCLES == 0) && last_dwell);

   next_slot_finder u_finder (
      .mask     (slot_mask),
      .cur_idx  (search_from),
      .next_idx (next_idx),
      .wrapped  (wrapped),
      .none     (none)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         binary_out <= '0;
         dec_enable <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         dwell_cnt  <= '0;
         blank_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         if (stop) begin
            state      <= IDLE;
            dec_enable <= 1'b0;
            busy       <= 1'b0;
         end else if (advance) begin
            if (none) begin
               state      <= IDLE;
               dec_enable <= 1'b0;
               busy       <= 1'b0;
            end else begin
               state      <= ACTIVE;
               binary_out <= next_idx;
               dwell_cnt  <= dwell_load;
               dec_enable <= 1'b1;
               frame_done <= wrapped;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !none) begin
                     state      <= ACTIVE;
                     binary_out <= next_idx;
                     dwell_cnt  <= dwell_load;
                     dec_enable <= 1'b1;
                     busy       <= 1'b1;
                  end
               end
               ACTIVE: begin
                  if (last_dwell) begin
                     state      <= BLANK;
                     dec_enable <= 1'b0;
                     blank_cnt  <= BLANK_LOAD;
                  end else begin
                     dwell_cnt <= dwell_cnt - DWELL_W'(1);
                  end
               end
               BLANK: blank_cnt <= blank_cnt - BLANK_W'(1);
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed and random checks of the scan sequencer against a
// time-since-slot-entry reference model.
module tb_decoder_scan_sequencer;
   import decoder_scan_pkg::*;

   localparam int DW = 8;
   localparam int B  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [DW-1:0] dwell = '0;
   logic [15:0]   slot_mask = '0;
   logic [3:0]    binary_out;
   logic          dec_enable;
   logic          busy;
   logic          frame_done;

   logic [15:0]   f_mask = '0;
   logic [3:0]    f_cur = '0;
   logic [3:0]    f_next;
   logic          f_wrapped;
   logic          f_none;

   int n_checks = 0;
   int n_fail = 0;
   int fd_cnt;

   bit m_busy = 0;
   bit m_fd = 0;
   int m_slot = 0;
   int m_t = 0;
   int m_d = 1;

   always #5 clk = ~clk;

   decoder_scan_sequencer #(.DWELL_W(DW), .BLANK_CYCLES(B)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .dwell      (dwell),
      .slot_mask  (slot_mask),
      .binary_out (binary_out),
      .dec_enable (dec_enable),
      .busy       (busy),
      .frame_done (frame_done)
   );

   next_slot_finder u_f (
      .mask     (f_mask),
      .cur_idx  (f_cur),
      .next_idx (f_next),
      .wrapped  (f_wrapped),
      .none     (f_none)
   );

   function automatic int lowest_bit(logic [15:0] m);
      for (int i = 0; i < 16; i++)
         if (m[i]) return i;
      return -1;
   endfunction

   function automatic int after(logic [15:0] m, int from);
      for (int k = 1; k <= 16; k++)
         if (m[(from + k) % 16]) return (from + k) % 16;
      return -1;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int n;
      if (!rst_n) begin
         m_busy = 0; m_fd = 0; m_slot = 0; m_t = 0; m_d = 1;
      end else if (stop) begin
         m_busy = 0; m_fd = 0;
      end else if (!m_busy) begin
         m_fd = 0;
         if (start && slot_mask != 0) begin
            m_slot = lowest_bit(slot_mask);
            m_t = 0;
            m_d = (dwell == 0) ? 1 : int'(dwell);
            m_busy = 1;
         end
      end else if (m_t == m_d + B - 1) begin
         n = after(slot_mask, m_slot);
         if (n < 0) begin
            m_busy = 0; m_fd = 0;
         end else begin
            m_fd = (n <= m_slot);
            m_slot = n;
            m_t = 0;
            m_d = (dwell == 0) ? 1 : int'(dwell);
         end
      end else begin
         m_t++;
         m_fd = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("binary_out", 32'(binary_out), 32'(m_slot));
      check("dec_enable", 32'(dec_enable), 32'(m_busy && (m_t < m_d)));
      check("busy", 32'(busy), 32'(m_busy));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      if (frame_done) fd_cnt++;
   endtask

   task automatic wait_slot(string tag, int target, int max_cycles);
      bit ok = 0;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (binary_out == 4'(target) && dec_enable) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL %s: slot %0d not reached, observed %0d", tag, target, binary_out);
      end
   endtask

   task automatic pulse_stop();
      stop = 1; tick(); stop = 0; tick();
   endtask

   initial begin
      int r;
      // reset
      rst_n = 0; tick(); tick();
      rst_n = 1; tick();
      check("rst_bo", 32'(binary_out), 0);
      check("rst_en", 32'(dec_enable), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fd", 32'(frame_done), 0);

      // full scan
      slot_mask = 16'hFFFF; dwell = 3;
      start = 1; tick(); start = 0;
      fd_cnt = 0;
      repeat (81) tick();
      check("full_fd_cnt", 32'(fd_cnt), 1);
      check("full_wrap_slot", 32'(binary_out), 0);
      pulse_stop();

      // sparse mask
      slot_mask = 16'h8101; dwell = 1;
      start = 1; tick(); start = 0;
      fd_cnt = 0;
      repeat (13) tick();
      check("sparse_fd_cnt", 32'(fd_cnt), 1);
      pulse_stop();

      // zero dwell, single bit
      slot_mask = 16'h0020; dwell = 0;
      start = 1; tick(); start = 0;
      check("single_first_fd", 32'(frame_done), 0);
      fd_cnt = 0;
      repeat (9) tick();
      check("single_fd_cnt", 32'(fd_cnt), 3);
      pulse_stop();

      // mask changes mid-scan
      slot_mask = 16'h000F; dwell = 3;
      start = 1; tick(); start = 0;
      wait_slot("reach_slot1", 1, 20);
      slot_mask = 16'h00F0;
      wait_slot("reach_slot4", 4, 20);
      check("mask_chg_slot", 32'(binary_out), 4);
      slot_mask = 16'h0000;
      for (int i = 0; i < 20 && busy; i++) tick();
      check("mask_clr_idle", 32'(busy), 0);
      check("mask_clr_hold", 32'(binary_out), 4);

      // stop at slot 6
      slot_mask = 16'h0040; dwell = 5;
      start = 1; tick(); start = 0; tick();
      stop = 1; tick(); stop = 0;
      check("stop_en", 32'(dec_enable), 0);
      check("stop_bo", 32'(binary_out), 6);
      check("stop_busy", 32'(busy), 0);
      tick();

      // start and stop together
      slot_mask = 16'hFFFF;
      start = 1; stop = 1; tick(); start = 0; stop = 0; tick();
      check("ss_busy", 32'(busy), 0);

      // reset during blank
      dwell = 1;
      start = 1; tick(); start = 0; tick();
      check("blank_en", 32'(dec_enable), 0);
      check("blank_busy", 32'(busy), 1);
      rst_n = 0; tick();
      check("mid_rst_bo", 32'(binary_out), 0);
      check("mid_rst_busy", 32'(busy), 0);
      rst_n = 1; tick();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 39) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 15) == 0) begin
            if (r < 10) slot_mask = '0;
            else if (r < 50) slot_mask = 16'(1 << $urandom_range(0, 15)) |
                                         16'(1 << $urandom_range(0, 15));
            else slot_mask = 16'($urandom);
         end
         dwell = DW'($urandom_range(0, 4));
         tick();
      end
      start = 0; stop = 0; rst_n = 1;

      // finder on its own
      for (int i = 0; i < 64; i++) begin
         int e;
         f_mask = (i % 8 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
         f_cur = 4'($urandom_range(0, 15));
         #1;
         e = after(f_mask, int'(f_cur));
         check("fnd_none", 32'(f_none), 32'(e < 0));
         if (e >= 0) begin
            check("fnd_next", 32'(f_next), 32'(e));
            check("fnd_wrap", 32'(f_wrapped), 32'(e <= int'(f_cur)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
